// File: rtl/nes_mem_pkg.sv
// Shared definitions for the SDRAM arbitration path: FSM states, owner codes,
// controller word width and the default byte-address width.
package nes_mem_pkg;

   localparam int SD_W       = 32;
   localparam int ADDR_W_DEF = 23;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_ACK
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_LD   = 2'd1,
      OWN_CPU  = 2'd2,
      OWN_PPU  = 2'd3
   } owner_t;

   // Bit order of the ack vector: {ppu, cpu, ld}.
   function automatic logic [2:0] ack_onehot(input owner_t o);
      case (o)
         OWN_LD:  ack_onehot = 3'b001;
         OWN_CPU: ack_onehot = 3'b010;
         OWN_PPU: ack_onehot = 3'b100;
         default: ack_onehot = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. last=1 means requester b was served most
// recently, so a wins a tie.
module rr_pick2 (
   input  logic req_a,
   input  logic req_b,
   input  logic last,
   output logic grant_a,
   output logic grant_b
);

   assign grant_a = req_a & (~req_b | last);
   assign grant_b = req_b & ~grant_a;

endmodule

// File: rtl/sdram_arbiter.sv
// Serializes loader / CPU / PPU byte accesses onto the single-port SDRAM
// controller. Loader has absolute priority; CPU and PPU alternate on ties.
module sdram_arbiter
   import nes_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_req,
   input  logic              cpu_req,
   input  logic              ppu_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [ADDR_W-1:0] ppu_addr,
   input  logic              ld_rw,
   input  logic              cpu_rw,
   input  logic              ppu_rw,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [DATA_W-1:0] ppu_wdata,
   output logic              ld_ack,
   output logic              cpu_ack,
   output logic              ppu_ack,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] sd_addr,
   output logic              sd_rw,
   output logic [SD_W-1:0]   sd_data_in,
   output logic              sd_in_valid,
   input  logic              sd_busy,
   input  logic [SD_W-1:0]   sd_data_out,
   input  logic              sd_out_valid,
   output logic [1:0]        owner
);

   state_t              state;
   owner_t              own_q, win;
   logic                last_rr;
   logic [2:0]          ack_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                g_cpu, g_ppu, done;
   logic [ADDR_W-1:0]   nxt_addr;
   logic                nxt_rw;
   logic [DATA_W-1:0]   nxt_wdata;
   logic                unused_hi;

   assign unused_hi  = ^sd_data_out[SD_W-1:DATA_W];
   assign sd_data_in = {{(SD_W-DATA_W){1'b0}}, wdata_q};
   assign owner      = own_q;
   assign ld_ack     = ack_q[0];
   assign cpu_ack    = ack_q[1];
   assign ppu_ack    = ack_q[2];

   rr_pick2 u_rr (
      .req_a   (cpu_req),
      .req_b   (ppu_req),
      .last    (last_rr),
      .grant_a (g_cpu),
      .grant_b (g_ppu)
   );

   always_comb begin
      win       = OWN_NONE;
      nxt_addr  = ld_addr;
      nxt_rw    = ld_rw;
      nxt_wdata = ld_wdata;
      if (ld_req) begin
         win = OWN_LD;
      end else if (g_cpu) begin
         win       = OWN_CPU;
         nxt_addr  = cpu_addr;
         nxt_rw    = cpu_rw;
         nxt_wdata = cpu_wdata;
      end else if (g_ppu) begin
         win       = OWN_PPU;
         nxt_addr  = ppu_addr;
         nxt_rw    = ppu_rw;
         nxt_wdata = ppu_wdata;
      end
   end

   // A read may return data before busy is ever seen high; accept it early.
   assign done = (state == ST_WAIT_BUSY && !sd_rw && sd_out_valid) ||
                 (state == ST_WAIT_DONE && (sd_rw ? !sd_busy : sd_out_valid));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         own_q       <= OWN_NONE;
         last_rr     <= 1'b1;
         ack_q       <= 3'b000;
         sd_in_valid <= 1'b0;
         rdata       <= '0;
         sd_addr     <= '0;
         sd_rw       <= 1'b0;
         wdata_q     <= '0;
      end else begin
         ack_q       <= 3'b000;
         sd_in_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!sd_busy && win != OWN_NONE) begin
                  own_q       <= win;
                  sd_addr     <= nxt_addr;
                  sd_rw       <= nxt_rw;
                  wdata_q     <= nxt_wdata;
                  sd_in_valid <= 1'b1;
                  state       <= ST_ISSUE;
                  if (win == OWN_CPU) last_rr <= 1'b0;
                  if (win == OWN_PPU) last_rr <= 1'b1;
               end else begin
                  own_q <= OWN_NONE;
               end
            end
            ST_ISSUE: state <= ST_WAIT_BUSY;
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
               if (done) begin
                  if (!sd_rw) rdata <= sd_data_out[DATA_W-1:0];
                  ack_q <= ack_onehot(own_q);
                  state <= ST_ACK;
               end else if (state == ST_WAIT_BUSY && sd_busy) begin
                  state <= ST_WAIT_DONE;
               end
            end
            ST_ACK: begin
               own_q <= OWN_NONE;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed requester traffic against a
// small busy/out_valid controller model; a negedge monitor checks every issue and ack.
module tb_sdram_arbiter;

   localparam int AW = 23;

   typedef struct {
      int         who;
      logic [22:0] addr;
      logic       rw;
      logic [7:0] wdata;
      logic [7:0] rd;
      int         req_cyc;
   } txn_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        ld_req = 0, cpu_req = 0, ppu_req = 0;
   logic [AW-1:0] ld_addr = 0, cpu_addr = 0, ppu_addr = 0;
   logic        ld_rw = 0, cpu_rw = 0, ppu_rw = 0;
   logic [7:0]  ld_wdata = 0, cpu_wdata = 0, ppu_wdata = 0;
   logic        ld_ack, cpu_ack, ppu_ack;
   logic [7:0]  rdata;
   logic [AW-1:0] sd_addr;
   logic        sd_rw, sd_in_valid, sd_busy;
   logic [31:0] sd_data_in;
   logic [31:0] sd_data_out = 0;
   logic        sd_out_valid = 0;
   logic [1:0]  owner;

   txn_t        exp_q[$];
   txn_t        ack_q[$];
   int          cyc = 0;
   int          timeouts = 0;
   bit          done = 0;
   int          checks = 0, failures = 0;
   logic [7:0]  cur_rd = 0;
   logic [1:0]  busy_cnt = 0;
   logic        rd_pend = 0;

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sdram_arbiter #(.ADDR_W(AW), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .ld_req(ld_req), .cpu_req(cpu_req), .ppu_req(ppu_req),
      .ld_addr(ld_addr), .cpu_addr(cpu_addr), .ppu_addr(ppu_addr),
      .ld_rw(ld_rw), .cpu_rw(cpu_rw), .ppu_rw(ppu_rw),
      .ld_wdata(ld_wdata), .cpu_wdata(cpu_wdata), .ppu_wdata(ppu_wdata),
      .ld_ack(ld_ack), .cpu_ack(cpu_ack), .ppu_ack(ppu_ack),
      .rdata(rdata), .sd_addr(sd_addr), .sd_rw(sd_rw), .sd_data_in(sd_data_in),
      .sd_in_valid(sd_in_valid), .sd_busy(sd_busy), .sd_data_out(sd_data_out),
      .sd_out_valid(sd_out_valid), .owner(owner)
   );

   // Controller model: busy for 3 cycles after a command; reads return data
   // in the last busy cycle. Keeps running across arbiter reset.
   assign sd_busy = (busy_cnt != 2'd0);
   always @(posedge clk) begin
      sd_out_valid <= 1'b0;
      if (sd_in_valid) begin
         busy_cnt <= 2'd3;
         rd_pend  <= !sd_rw;
      end else if (busy_cnt != 2'd0) begin
         busy_cnt <= busy_cnt - 2'd1;
         if (rd_pend && busy_cnt == 2'd2) begin
            sd_out_valid <= 1'b1;
            sd_data_out  <= {24'h0, cur_rd};
            rd_pend      <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor / scoreboard
   initial begin : monitor
      logic [7:0] exp_rdata;
      logic       prev_busy, rst_prev, cur_rw;
      int         last_ev, nack;
      txn_t       e;
      exp_rdata = 0; prev_busy = 0; rst_prev = 0; cur_rw = 0; last_ev = -10;
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            chk("rst_in_valid", {31'b0, sd_in_valid}, 0);
            chk("rst_acks", {29'b0, ld_ack, cpu_ack, ppu_ack}, 0);
            chk("rst_owner", {30'b0, owner}, 0);
            chk("rst_rdata", {24'b0, rdata}, 0);
            chk("rst_cmd", {8'b0, sd_rw, sd_addr}, 0);
            chk("rst_data_in", sd_data_in, 0);
         end
         if (rst) begin
            exp_rdata = 0;
         end else begin
            if (sd_in_valid) begin
               chk("issue_while_busy", {31'b0, prev_busy}, 0);
               if (exp_q.size() == 0) begin
                  chk("unexpected_issue", {30'b0, owner}, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("issue_owner", {30'b0, owner}, e.who);
                  chk("issue_addr", {9'b0, sd_addr}, {9'b0, e.addr});
                  chk("issue_rw", {31'b0, sd_rw}, {31'b0, e.rw});
                  chk("issue_data_in", sd_data_in, {24'h0, e.wdata});
                  if (e.req_cyc >= 0) chk("issue_latency", cyc, e.req_cyc + 1);
                  cur_rw = e.rw;
                  cur_rd = e.rd;
               end
            end
            if (sd_out_valid) last_ev = cyc;
            if (prev_busy && !sd_busy && cur_rw) last_ev = cyc;
            nack = int'(ld_ack) + int'(cpu_ack) + int'(ppu_ack);
            if (nack > 1) chk("ack_overlap", nack, 1);
            if (nack != 0) begin
               if (ack_q.size() == 0) begin
                  chk("unexpected_ack", {29'b0, ld_ack, cpu_ack, ppu_ack}, 0);
               end else begin
                  e = ack_q.pop_front();
                  chk("ack_who", ld_ack ? 1 : cpu_ack ? 2 : 3, e.who);
                  if (!e.rw) exp_rdata = e.rd;
                  chk("ack_rdata", {24'b0, rdata}, {24'b0, exp_rdata});
                  chk("ack_latency", cyc, last_ev + 1);
               end
            end
         end
         prev_busy = sd_busy;
         rst_prev  = rst;
         if (done) break;
      end
      chk("issues_pending", exp_q.size(), 0);
      chk("acks_pending", ack_q.size(), 0);
      chk("req_timeouts", timeouts, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic expect_txn(input int who, input logic [22:0] a, input logic rw,
                             input logic [7:0] wd, input logic [7:0] rd,
                             input int req_cyc, input bit acked);
      txn_t t;
      t.who = who; t.addr = a; t.rw = rw; t.wdata = wd; t.rd = rd; t.req_cyc = req_cyc;
      exp_q.push_back(t);
      if (acked) ack_q.push_back(t);
   endtask

   function automatic logic ack_of(input int who);
      return (who == 1) ? ld_ack : (who == 2) ? cpu_ack : ppu_ack;
   endfunction

   task automatic drive(input int who, input logic r, input logic [22:0] a,
                        input logic rw, input logic [7:0] wd);
      case (who)
         1: begin ld_req = r;  ld_addr = a;  ld_rw = rw;  ld_wdata = wd;  end
         2: begin cpu_req = r; cpu_addr = a; cpu_rw = rw; cpu_wdata = wd; end
         default: begin ppu_req = r; ppu_addr = a; ppu_rw = rw; ppu_wdata = wd; end
      endcase
   endtask

   task automatic wait_ack(input int who);
      bit got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = ack_of(who);
      end
      if (!got) timeouts++;
   endtask

   // Raise req (at a negedge), hold until ack, then drop.
   task automatic run_req(input int who, input logic [22:0] a, input logic rw,
                          input logic [7:0] wd);
      drive(who, 1'b1, a, rw, wd);
      wait_ack(who);
      drive(who, 1'b0, a, rw, wd);
   endtask

   task automatic wait_issue();
      bit got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = sd_in_valid;
      end
      if (!got) timeouts++;
   endtask

   initial begin : stim
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // All three at once: loader, then CPU (last_rr resets to PPU), then PPU.
      expect_txn(1, 23'h000010, 1'b1, 8'h55, 8'h00, -1, 1);
      expect_txn(2, 23'h000100, 1'b0, 8'h00, 8'h5A, -1, 1);
      expect_txn(3, 23'h002000, 1'b0, 8'h00, 8'hC3, -1, 1);
      fork
         run_req(1, 23'h000010, 1'b1, 8'h55);
         run_req(2, 23'h000100, 1'b0, 8'h00);
         run_req(3, 23'h002000, 1'b0, 8'h00);
      join
      repeat (4) @(negedge clk);

      // CPU read with issue latency check.
      expect_txn(2, 23'h001234, 1'b0, 8'h00, 8'hA5, cyc, 1);
      run_req(2, 23'h001234, 1'b0, 8'h00);
      repeat (4) @(negedge clk);

      // Loader write to top address; rdata must stay 0xA5.
      expect_txn(1, 23'h7FFFFF, 1'b1, 8'h3C, 8'h00, -1, 1);
      run_req(1, 23'h7FFFFF, 1'b1, 8'h3C);
      repeat (4) @(negedge clk);

      // Reset in WAIT_DONE with controller busy; CPU req held throughout.
      expect_txn(2, 23'h000ABC, 1'b0, 8'h00, 8'h11, -1, 0);
      expect_txn(2, 23'h000ABC, 1'b0, 8'h00, 8'h22, -1, 1);
      drive(2, 1'b1, 23'h000ABC, 1'b0, 8'h00);
      wait_issue();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_ack(2);
      drive(2, 1'b0, 23'h000ABC, 1'b0, 8'h00);
      repeat (4) @(negedge clk);

      // Fresh reset so the CPU wins the first tie of the continuous run.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         expect_txn(2, 23'h000200 + 23'(k), 1'b0, 8'h00, 8'h80 + 8'(k), -1, 1);
         expect_txn(3, 23'h001F00 + 23'(k), 1'b1, 8'hE0 + 8'(k), 8'h00, -1, 1);
      end
      fork
         for (int k = 0; k < 4; k++) run_req(2, 23'h000200 + 23'(k), 1'b0, 8'h00);
         for (int m = 0; m < 4; m++) run_req(3, 23'h001F00 + 23'(m), 1'b1, 8'hE0 + 8'(m));
      join
      repeat (4) @(negedge clk);

      // PPU drops req in WAIT_BUSY: one ack, no reissue.
      expect_txn(3, 23'h003FF0, 1'b0, 8'h00, 8'h77, -1, 1);
      drive(3, 1'b1, 23'h003FF0, 1'b0, 8'h00);
      wait_issue();
      @(negedge clk);
      drive(3, 1'b0, 23'h003FF0, 1'b0, 8'h00);
      wait_ack(3);
      repeat (20) @(negedge clk);
      done = 1;
   end

endmodule
